jtdd_com: RTL

MCU-side end of the main-CPU/MCU communication channel in the Double Dragon core. It owns the 512-byte shared communication RAM and arbitrates it between the MCU and the main 6809. The arbitration is a halt-request/bus-available handshake: the main CPU may only touch the RAM while the MCU is halted. The block also generates the MCU NMI from main-CPU writes, and the main-CPU interrupt from MCU writes.

---
 rtl/jtdd_pkg.sv | 15 +
 rtl/jtframe_ram.sv | 28 ++
 rtl/jtdd_com.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/jtdd_pkg.sv
// Shared definitions for the main-CPU/MCU communication channel.
//   com_st_t : arbiter ownership state of the shared com RAM
//   COM_AW   : default address width of the 512-byte com RAM
package jtdd_pkg;

    typedef enum logic [1:0] {
        MCU_OWN  = 2'd0,   // MCU drives the RAM, no halt requested
        REQ      = 2'd1,   // halt requested, waiting for MCU bus-available
        MAIN_OWN = 2'd2,   // MCU halted, main 6809 drives the RAM
        REL      = 2'd3    // halt released, waiting for MCU to drop bus-available
    } com_st_t;

    localparam int COM_AW = 9;

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, read-before-write.
//   clk, cen : clock and clock enable
//   addr     : address
//   data, we : write data and write enable
//   q        : registered read data (old contents on a same-cycle write)
// Contents are never reset.
module jtframe_ram #(
    parameter int aw = 9,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] data,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:(2**aw)-1];

    always_ff @(posedge clk) begin
        if (cen) begin
            q <= mem[addr];
            if (we) mem[addr] <= data;
        end
    end

endmodule

// File: rtl/jtdd_com.sv
// MCU-side end of the main-CPU/MCU channel of the Double Dragon core.
// Owns the shared 512-byte com RAM and arbitrates it with a halt-request /
// bus-available handshake, generates the MCU NMI from main writes and the
// main IRQ from MCU writes. All state advances on cen only.
//
// Ports:
//   clk, nRESET (async, active-low), cen
//   main_halt_set/main_halt_clr : request / release MCU halt
//   main_nmi, main_irq_clr      : fire MCU NMI / acknowledge main IRQ
//   main_cs/rnw/addr/din/dout   : main access to the com RAM
//   main_ba, main_irq_n         : main owns the RAM / main interrupt
//   mcu_halt_n, mcu_ba          : halt request to MCU / MCU acknowledge
//   mcu_nmi_n, mcu_irq_set      : MCU NMI / MCU raises main IRQ
//   mcu_cs/rnw/addr/din/dout    : MCU access to the com RAM
//
// Build option: define JTDD_COM_TIMEOUT_EN to abandon a halt request after
// TOUT cen cycles without mcu_ba.
module jtdd_com
    import jtdd_pkg::*;
#(
    parameter int AW   = COM_AW,
    parameter int NMIW = 4,
    parameter int TOUT = 1023
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          cen,
    input  logic          main_halt_set,
    input  logic          main_halt_clr,
    input  logic          main_nmi,
    input  logic          main_irq_clr,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_din,
    output logic [7:0]    main_dout,
    output logic          main_ba,
    output logic          main_irq_n,
    output logic          mcu_halt_n,
    input  logic          mcu_ba,
    output logic          mcu_nmi_n,
    input  logic          mcu_cs,
    input  logic          mcu_rnw,
    input  logic [AW-1:0] mcu_addr,
    input  logic [7:0]    mcu_din,
    output logic [7:0]    mcu_dout,
    input  logic          mcu_irq_set
);

    localparam int NW = $clog2(NMIW + 1);

    com_st_t       st, st_nxt;
    logic          main_own;
    logic          tout_hit;
    logic [NW-1:0] nmi_cnt;
    logic          main_rd_sel, mcu_rd_sel;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din, ram_q;
    logic          ram_we;

`ifdef JTDD_COM_TIMEOUT_EN
    localparam int TW = $clog2(TOUT + 1);
    logic [TW-1:0] to_cnt;

    // to_cnt holds the number of cen cycles already spent in REQ
    assign tout_hit = to_cnt == TW'(TOUT - 1);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            to_cnt <= '0;
        end else if (cen) begin
            to_cnt <= (st == REQ && st_nxt == REQ) ? to_cnt + TW'(1) : '0;
        end
    end
`else
    assign tout_hit = 1'b0;
    // TOUT only matters in the timeout build
    if (TOUT < 1) begin : g_tout_unused
    end
`endif

    // Arbiter state register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) st <= MCU_OWN;
        else if (cen) st <= st_nxt;
    end

    // Arbiter next state and decoded outputs
    always_comb begin
        st_nxt     = st;
        mcu_halt_n = 1'b1;
        main_ba    = 1'b0;
        main_own   = 1'b0;
        unique case (st)
            MCU_OWN: begin
                if (main_halt_set) st_nxt = REQ;
            end
            REQ: begin
                mcu_halt_n = 1'b0;
                if (main_halt_clr)  st_nxt = REL;
                else if (mcu_ba)    st_nxt = MAIN_OWN;
                else if (tout_hit)  st_nxt = REL;
            end
            MAIN_OWN: begin
                mcu_halt_n = 1'b0;
                main_ba    = 1'b1;
                main_own   = 1'b1;
                if (main_halt_clr) st_nxt = REL;
            end
            REL: begin
                if (main_halt_set) st_nxt = REQ;
                else if (!mcu_ba)  st_nxt = MCU_OWN;
            end
            default: st_nxt = MCU_OWN;
        endcase
    end

    // RAM port mux: the registered state selects the owner, so a change of
    // ownership only applies from the cen after the state moves.
    always_comb begin
        ram_addr = mcu_addr;
        ram_din  = mcu_din;
        ram_we   = mcu_cs & ~mcu_rnw;
        if (main_own) begin
            ram_addr = main_addr;
            ram_din  = main_din;
            ram_we   = main_cs & ~main_rnw;
        end
    end

    jtframe_ram #(.aw(AW), .dw(8)) u_ram (
        .clk  (clk),
        .cen  (cen),
        .addr (ram_addr),
        .data (ram_din),
        .we   (ram_we),
        .q    (ram_q)
    );

    // Remember who owned the RAM when the read was issued so the non-owner
    // sees 8'hFF alongside the registered RAM data.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            main_rd_sel <= 1'b0;
            mcu_rd_sel  <= 1'b0;
        end else if (cen) begin
            main_rd_sel <= main_own;
            mcu_rd_sel  <= ~main_own;
        end
    end

    assign main_dout = main_rd_sel ? ram_q : 8'hFF;
    assign mcu_dout  = mcu_rd_sel  ? ram_q : 8'hFF;

    // MCU NMI: a retrigger reloads the counter, stretching the pulse
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            nmi_cnt <= '0;
        end else if (cen) begin
            if (main_nmi)            nmi_cnt <= NW'(NMIW);
            else if (nmi_cnt != '0)  nmi_cnt <= nmi_cnt - NW'(1);
        end
    end

    assign mcu_nmi_n = nmi_cnt == '0;

    // Main IRQ flag, set has priority over clear
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            main_irq_n <= 1'b1;
        end else if (cen) begin
            if (mcu_irq_set)       main_irq_n <= 1'b0;
            else if (main_irq_clr) main_irq_n <= 1'b1;
        end
    end

endmodule
